// File: rtl/register_out_fifo.sv
// register_out_fifo
//   Output-side FIFO behind the CPU's store-to-output register. The CPU
//   pushes words with a one-cycle load strobe. An external consumer drains
//   the words in order with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = in reset)
//   load       push data_in this cycle
//   data_in    word to push
//   flush      synchronous discard of every queued entry
//   clr_ovf    synchronous clear of the sticky overflow flag
//   out_ready  consumer takes the head word this cycle
//   out_valid  a head word is present (== !empty)
//   data_out   head word; when empty, the last popped word (HOLD_LAST=1) or zero
//   full       count == DEPTH
//   empty      count == 0
//   count      number of queued entries
//   overflow   sticky; set when a load is dropped because the queue is full
module register_out_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter bit          HOLD_LAST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       flush,
  input  logic                       clr_ovf,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] held_q, held_d;

  logic             pop;
  logic             push;
  logic             drop;
  logic             is_full;
  logic             is_empty;
  logic [WIDTH-1:0] head;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign pop  = !is_empty && out_ready;
  assign push = load && !flush && (!is_full || pop);
  assign drop = load && !flush && is_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    held_d   = held_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      held_d   = head;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over push/pop bookkeeping. A pop in the same cycle has
    // already updated the held value above, so that value is kept.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A dropped load beats a simultaneous clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      held_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      held_q   <= held_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign out_valid = !is_empty;
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign data_out  = !is_empty ? head : (HOLD_LAST ? held_q : '0);

endmodule
